// File: rtl/sys_mem_arbiter.sv
// rtl/sys_mem_arbiter.sv - round-robin N-port arbiter onto one shared word-addressed memory
module sys_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_strobe,
    input  logic [NUM_PORTS-1:0]            req_rw,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            req_error,
    output logic                            mem_enable,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_in,
    input  logic [DATA_WIDTH-1:0]           mem_out,
    input  logic                            mem_ready
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PW-1:0]          prio_ptr;
    logic [PW-1:0]          grant_q;
    logic [PW-1:0]          pick;
    logic [PW-1:0]          idx;
    logic                   pick_valid;
    logic                   load;
    logic                   done_ok;
    logic                   done_err;
    logic                   rw_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [CW-1:0]          cnt_q;
    logic [NUM_PORTS-1:0]   ready_q;
    logic [NUM_PORTS-1:0]   error_q;

    // Scan ports starting at prio_ptr, wrapping by compare so any port count works.
    always_comb begin
        pick       = prio_ptr;
        pick_valid = 1'b0;
        idx        = prio_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!pick_valid && req_strobe[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
            idx = (idx == LAST_PORT) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                // A late mem_ready on the boundary cycle still wins over the timeout.
                if (mem_ready) begin
                    state_d = RESP;
                    done_ok = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d  = RESP;
                    done_err = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr <= '0;
            grant_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= '0;
            error_q  <= '0;
        end else begin
            ready_q <= '0;
            error_q <= '0;
            if (load) begin
                grant_q <= pick;
                rw_q    <= req_rw[pick];
                addr_q  <= req_address[pick*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                cnt_q   <= '0;
            end
            if ((state_q == ACCESS) && !done_ok && !done_err) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done_ok && rw_q) begin
                rdata_q <= mem_out;
            end
            if (done_ok) begin
                ready_q[grant_q] <= 1'b1;
            end
            if (done_err) begin
                error_q[grant_q] <= 1'b1;
            end
            if (state_q == RESP) begin
                prio_ptr <= (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign mem_enable  = (state_q == ACCESS);
    assign mem_read    = mem_enable & rw_q;
    assign mem_write   = mem_enable & ~rw_q;
    assign mem_address = addr_q;
    assign mem_in      = wdata_q;
    assign req_rdata   = rdata_q;
    assign req_ready   = ready_q;
    assign req_error   = error_q;

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// tb/tb_sys_mem_arbiter.sv - self-checking bench for sys_mem_arbiter
module tb_sys_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req_strobe;
    logic [NP-1:0]     req_rw;
    logic [NP*AW-1:0]  req_address;
    logic [NP*DW-1:0]  req_wdata;
    logic [DW-1:0]     req_rdata;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     req_error;
    logic              mem_enable;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_in;
    logic [DW-1:0]     mem_out;
    logic              mem_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;

    sys_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_strobe(req_strobe), .req_rw(req_rw),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .req_ready(req_ready), .req_error(req_error),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_in(mem_in),
        .mem_out(mem_out), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: latency = addr[1:0] extra cycles; addr[2:0]==7 never answers.
    function automatic logic [31:0] init_word(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : ({8'hC5, 12'h000, a} ^ {a, 20'h5A5A5});
    endfunction

    logic [31:0] mem_arr [4096];
    bit          written [4096];
    int          en_cycles = 0;

    always @(posedge clk) begin
        if (mem_enable && mem_ready && mem_write) begin
            mem_arr[mem_address] <= mem_in;
            written[mem_address] <= 1'b1;
        end
        en_cycles <= mem_enable ? en_cycles + 1 : 0;
    end

    assign mem_ready = mem_enable && (mem_address[2:0] != 3'd7) &&
                       (en_cycles == int'(mem_address[1:0]));
    assign mem_out   = written[mem_address] ? mem_arr[mem_address] : init_word(mem_address);

    always @(negedge clk) begin
        if (!rst && cycle > 0) begin
            n_assert++;
            assert ($countones(req_ready | req_error) <= 1) else begin
                n_fail++;
                $error("FAIL onehot: observed ready=%b error=%b expected at most one bit", req_ready, req_error);
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [4096];
    int          ref_ptr;
    logic [31:0] last_rdata;
    bit          active [NP];
    bit          p_rw   [NP];
    logic [11:0] p_addr [NP];
    logic [31:0] p_wdata[NP];

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit rw, input logic [11:0] a, input logic [31:0] d);
        req_rw[p]            = rw;
        req_address[p*AW +: AW] = a;
        req_wdata[p*DW +: DW]   = d;
    endtask

    task automatic issue(input int p);
        active[p]  = 1'b1;
        p_rw[p]    = 1'($urandom);
        p_addr[p]  = 12'($urandom);
        p_wdata[p] = $urandom;
        set_req(p, p_rw[p], p_addr[p], p_wdata[p]);
        req_strobe[p] = 1'b1;
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < NP; i++) begin
            if (active[(ref_ptr + i) % NP]) return (ref_ptr + i) % NP;
        end
        return -1;
    endfunction

    function automatic int access_cycles(input logic [11:0] a);
        return (a[2:0] == 3'd7) ? TO : int'(a[1:0]) + 1;
    endfunction

    // Serves all active requests; new requests are issued only on response cycles.
    task automatic engine(input int n_new_in, input bit saturate);
        int n_new, ref_time, exp_p, p, budget, any;
        logic [NP-1:0] pulse;
        bit ok;
        n_new    = n_new_in;
        ref_time = cycle - 1;
        while (rr_pick() >= 0) begin
            exp_p  = rr_pick();
            budget = 0;
            pulse  = '0;
            while (pulse == '0 && budget < 20) begin
                tick();
                budget++;
                pulse = req_ready | req_error;
            end
            chk("response_seen", 64'(pulse != '0), 64'd1);
            if (pulse == '0) return;
            p = 0;
            for (int i = NP - 1; i >= 0; i--) if (pulse[i]) p = i;
            ok = (p_addr[exp_p][2:0] != 3'd7);
            chk("rr_winner", 64'(p), 64'(exp_p));
            chk("latency", 64'(cycle - ref_time), 64'(access_cycles(p_addr[exp_p]) + 2));
            chk("status", {62'd0, req_ready[exp_p], req_error[exp_p]}, ok ? 64'd2 : 64'd1);
            if (ok && p_rw[exp_p]) last_rdata = ref_mem[p_addr[exp_p]];
            if (ok && !p_rw[exp_p]) ref_mem[p_addr[exp_p]] = p_wdata[exp_p];
            chk("rdata", 64'(req_rdata), 64'(last_rdata));
            ref_ptr  = (exp_p + 1) % NP;
            ref_time = cycle;
            active[p]     = 1'b0;
            req_strobe[p] = 1'b0;
            if (n_new > 0) begin
                if (saturate) begin
                    issue(p);
                    n_new--;
                end else begin
                    for (int q = 0; q < NP; q++) begin
                        if (!active[q] && n_new > 0 && $urandom_range(1, 0) == 1) begin
                            issue(q);
                            n_new--;
                        end
                    end
                    any = rr_pick();
                    if (any < 0 && n_new > 0) begin
                        issue($urandom_range(NP - 1, 0));
                        n_new--;
                    end
                end
            end
        end
        tick();
        tick();
    endtask

    initial begin
        int en_cnt, err_cnt, rdy_cnt, bad_cnt;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(12'(i));
        for (int i = 0; i < NP; i++) active[i] = 1'b0;
        rst = 1'b1;
        req_strobe = '0; req_rw = '0; req_address = '0; req_wdata = '0;
        ref_ptr = 0;
        last_rdata = '0;
        tick();
        tick();

        // Reset state
        chk("reset_mem_ctl", {61'd0, mem_enable, mem_read, mem_write}, 64'd0);
        chk("reset_mem_addr_in", {20'd0, mem_address, mem_in}, 64'd0);
        chk("reset_rdata", 64'(req_rdata), 64'd0);
        chk("reset_pulses", {58'd0, req_ready, req_error}, 64'd0);
        rst = 1'b0;
        tick();

        // Single read on port 1, memory answers at once
        set_req(1, 1'b1, 12'h010, 32'h0);
        req_strobe[1] = 1'b1;
        tick();
        chk("single_en", {61'd0, mem_enable, mem_read, mem_write}, 64'b110);
        chk("single_addr", 64'(mem_address), 64'h010);
        chk("single_no_ready_yet", 64'(req_ready), 64'd0);
        tick();
        chk("single_en_drop", 64'(mem_enable), 64'd0);
        chk("single_ready", 64'(req_ready), 64'b010);
        chk("single_rdata", 64'(req_rdata), 64'hDEADBEEF);
        req_strobe[1] = 1'b0;
        tick();
        chk("single_ready_pulse", 64'(req_ready), 64'd0);
        ref_ptr = 2;
        last_rdata = 32'hDEADBEEF;

        // Simultaneous requests straight out of reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_ptr = 0;
        last_rdata = '0;
        active[0] = 1'b1; p_rw[0] = 1'b0; p_addr[0] = 12'h004; p_wdata[0] = 32'h12345678;
        active[1] = 1'b1; p_rw[1] = 1'b1; p_addr[1] = 12'h008; p_wdata[1] = 32'h0;
        set_req(0, 1'b0, 12'h004, 32'h12345678);
        set_req(1, 1'b1, 12'h008, 32'h0);
        req_strobe = 3'b011;
        engine(0, 1'b0);
        chk("simul_mem_written", 64'(mem_arr[12'h004]), 64'h12345678);

        // Timeout on a memory that never answers
        set_req(0, 1'b1, 12'h007, 32'h0);
        req_strobe[0] = 1'b1;
        en_cnt = 0; err_cnt = 0; rdy_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_enable) en_cnt++;
            if (req_ready != '0) rdy_cnt++;
            if (req_error === 3'b001) begin
                err_cnt++;
                req_strobe[0] = 1'b0;
            end else if (req_error != '0) begin
                bad_cnt++;
            end
        end
        req_strobe[0] = 1'b0;
        chk("timeout_en_cycles", 64'(en_cnt), 64'(TO));
        chk("timeout_error_pulses", 64'(err_cnt), 64'd1);
        chk("timeout_stray_error", 64'(bad_cnt), 64'd0);
        chk("timeout_no_ready", 64'(rdy_cnt), 64'd0);
        chk("timeout_rdata_kept", 64'(req_rdata), 64'(last_rdata));
        ref_ptr = 1;
        active[0] = 1'b1; p_rw[0] = 1'b1; p_addr[0] = 12'h00C; p_wdata[0] = 32'h0;
        set_req(0, 1'b1, 12'h00C, 32'h0);
        req_strobe[0] = 1'b1;
        engine(0, 1'b0);

        // Inputs changed after the grant are ignored
        set_req(0, 1'b0, 12'h023, 32'hCAFEF00D);
        req_strobe[0] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("latched_en", {62'd0, mem_enable, mem_write}, 64'b11);
            chk("latched_addr", 64'(mem_address), 64'h023);
            chk("latched_wdata", 64'(mem_in), 64'hCAFEF00D);
            if (i == 0) set_req(0, 1'b1, 12'h033, 32'h0);
            tick();
        end
        chk("latched_ready", 64'(req_ready), 64'b001);
        req_strobe[0] = 1'b0;
        ref_mem[12'h023] = 32'hCAFEF00D;
        ref_ptr = 1;
        tick();
        tick();

        // Reset during ACCESS aborts the transaction
        set_req(1, 1'b1, 12'h007, 32'h0);
        req_strobe[1] = 1'b1;
        tick();
        chk("rstmid_in_access", 64'(mem_enable), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_strobe[1] = 1'b0;
        chk("rstmid_mem_ctl", {61'd0, mem_enable, mem_read, mem_write}, 64'd0);
        chk("rstmid_mem_addr_in", {20'd0, mem_address, mem_in}, 64'd0);
        chk("rstmid_rdata", 64'(req_rdata), 64'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if ((req_ready | req_error) != '0) rdy_cnt++;
            tick();
        end
        chk("rstmid_no_pulse", 64'(rdy_cnt), 64'd0);
        ref_ptr = 0;
        last_rdata = '0;

        // Saturation: every port always requesting
        for (int q = 0; q < NP; q++) issue(q);
        engine(9, 1'b1);

        // Random traffic
        engine(60, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_mem_arbiter.md
# sys_mem_arbiter

Parametrised N-port memory arbiter between the per-core cache system ports (instruction cache, data cache, further requesters) and a single shared word-addressed memory. It is the successor to wiring each cache to its own IM/DM memory: any number of requesters share one memory bus through round-robin arbitration. Each transaction has a bounded wait, and transactions that never complete abort with an error pulse. The block sits between the cache `Sys*` ports and the top-level memory pins.

## Interface
- `NUM_PORTS`, 2: number of requesters, ≥1; port 0 is LSB slice of every packed bus
- `ADDR_WIDTH`, 12: memory word-address width
- `DATA_WIDTH`, 32: data width
- `TIMEOUT`, 0: max cycles waiting for `mem_ready`; 0 = wait forever
- `clk`  in  1  single clock; everything on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_strobe`  in  NUM_PORTS  request valid per port, held until that port's `req_ready`/`req_error`
- `req_rw`  in  NUM_PORTS  1 = read, 0 = write (same sense as cache `SysRW`)
- `req_address`  in  NUM_PORTS*ADDR_WIDTH  packed addresses
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  packed write data
- `req_rdata`  out  DATA_WIDTH  read data, shared; valid only with `req_ready` of a read
- `req_ready`  out  NUM_PORTS  one-cycle completion pulse to the served port
- `req_error`  out  NUM_PORTS  one-cycle timeout pulse to the served port
- `mem_enable`  out  1  memory access strobe
- `mem_read`  out  1  memory read select
- `mem_write`  out  1  memory write select
- `mem_address`  out  ADDR_WIDTH  memory address
- `mem_in`  out  DATA_WIDTH  write data to memory
- `mem_out`  in  DATA_WIDTH  read data from memory
- `mem_ready`  in  1  memory completion, sampled only while `mem_enable`=1

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE: if any `req_strobe` is set, pick a winner by round-robin from `prio_ptr`.
  - Latch the winner's index, rw, address and wdata into internal registers.
  - Go to ACCESS and clear the wait counter.
  - No request: stay in IDLE.
- ACCESS: drive from the latched registers, never combinationally from `req_*`:
  - `mem_enable`=1; `mem_read`=rw; `mem_write`=!rw; `mem_address`/`mem_in` from the latched values.
  - On `mem_ready`: capture `mem_out` into the rdata register (reads only) and go to RESP with status OK.
  - Otherwise, if `TIMEOUT`≠0 and the counter = `TIMEOUT`-1: go to RESP with status ERR.
  - Otherwise: increment the counter.
- RESP:
  - Status OK: pulse `req_ready[grant]`. Status ERR: pulse `req_error[grant]`.
  - Set `prio_ptr` = (grant+1) mod `NUM_PORTS`, then return to IDLE.
- Round-robin: the port at `prio_ptr` has highest priority, then ascending index with wrap-around. Wrap uses a compare, not a power-of-two mask.
- Requester changes to `req_*` after the grant are ignored until the next IDLE.
- A strobe still high in the IDLE following its RESP is treated as a new request. Caches drop the strobe on `ready`, so this does not arise in normal use.
- `NUM_PORTS`=1 degenerates to a registered pass-through with timeout. The pointer stays 0.
- Internal widths:
  - grant index and `prio_ptr`: `$clog2(NUM_PORTS)`, minimum 1 bit.
  - wait counter: `$clog2(TIMEOUT+1)`, minimum 1 bit.

## Timing
- Reset values:
  - state IDLE, `prio_ptr`=0, counter=0.
  - `mem_enable`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_in`=0.
  - `req_rdata`=0, `req_ready`=0, `req_error`=0.
- Reset mid-transaction aborts it. In the cycle after `rst`, `mem_enable`=0 and no ready/error pulse is issued.
- Request seen at edge T (IDLE):
  - `mem_enable`=1 from T+1.
  - If `mem_ready` is sampled at edge T+k, `req_ready` is high for the cycle after T+k.
  - Next arbitration edge is T+k+2.
- Minimum latency is strobe→ready = 3 cycles (memory answers in its first ACCESS cycle). Back-to-back throughput is one transaction per 3 cycles.
- `req_rdata` holds its last captured value until the next read completes. It is not cleared on writes or errors.
- Timeout: with `TIMEOUT`=N, an access without `mem_ready` leaves ACCESS after exactly N cycles of `mem_enable`=1.
- `mem_ready` arriving in the same cycle as the timeout boundary counts as success.
- Outputs `req_ready`/`req_error` are registered. At most one bit of `req_ready|req_error` is set in any cycle.

## Test plan
- Single read, `NUM_PORTS`=2. Setup: port1 reads 0x010, memory answers `mem_ready` in its 1st ACCESS cycle with 0xDEADBEEF. Required:
  - `mem_enable` high 1 cycle with `mem_read`=1.
  - `req_ready`=2'b10 three cycles after the strobe, with `req_rdata`=0xDEADBEEF.
- Simultaneous requests. Setup: both ports strobe at once from reset (port0 write 0x004←0x12345678, port1 read 0x008). Required:
  - port0 served first, then port1 (`prio_ptr` was 0).
  - memory sees the write, then the read; `req_ready` 2'b01 then 2'b10.
- Fairness under saturation. Setup: `NUM_PORTS`=3, all strobes held permanently high. Required: grant order 0,1,2,0,1,2…; no port is served twice before each other port is served once.
- Timeout. Setup: `TIMEOUT`=4, `mem_ready` stuck at 0, port0 read. Required:
  - `mem_enable` high for exactly 4 cycles.
  - `req_error`=2'b01 for 1 cycle; `req_ready` never set.
  - `req_rdata` unchanged; next request proceeds normally.
- Reset mid-access. Setup: assert `rst` during ACCESS. Required:
  - next cycle `mem_enable`=0 and all outputs at their reset values.
  - no ready/error pulse; `prio_ptr`=0.
- Latched inputs. Setup: change port0 address from 0x020 to 0x030 after the grant. Required: `mem_address` stays 0x020 for the whole access.
